// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the interrupt sequencer: sequencer states,
// interrupt kinds, vector addresses and status-register bit constants.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DUMMY,
    PUSH_PCH,
    PUSH_PCL,
    PUSH_P,
    VEC_L,
    VEC_H,
    RST_HOLD
  } int_state_t;

  typedef enum logic [1:0] {
    RST,
    NMI,
    IRQ,
    BRK
  } int_kind_t;

  localparam logic [15:0] VEC_NMI    = 16'hFFFA;
  localparam logic [15:0] VEC_RST    = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ    = 16'hFFFE;
  localparam logic [7:0]  STACK_PAGE = 8'h01;

  // P bit 5 always reads as 1 when pushed; bit 4 (B) marks a software BRK.
  localparam logic [7:0]  P_UNUSED   = 8'h20;
  localparam logic [7:0]  P_BREAK    = 8'h10;

  function automatic logic [15:0] vector_base(input int_kind_t kind);
    logic [15:0] base;
    case (kind)
      RST:     base = VEC_RST;
      NMI:     base = VEC_NMI;
      default: base = VEC_IRQ;
    endcase
    return base;
  endfunction

endpackage

// File: rtl/nmi_edge_detector.sv
// Latches a falling edge of the active-low NMI line into a sticky pending
// flag. Sampling and clearing both freeze while cpu_en is low.
module nmi_edge_detector (
  input  logic clk,
  input  logic reset,
  input  logic cpu_en,
  input  logic nmi_n,
  input  logic clear,
  output logic nmi_pending
);

  logic nmi_n_q, nmi_n_d;
  logic pending_q, pending_d;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    nmi_n_d   = nmi_n_q;
    pending_d = pending_q;
    if (cpu_en) begin
      nmi_n_d = nmi_n;
      if (clear) begin
        pending_d = 1'b0;
      end
      // A fresh edge wins over a same-cycle clear so it is never lost.
      if (nmi_n_q && !nmi_n) begin
        pending_d = 1'b1;
      end
    end
  end

  // NOTE: the line history reloads from the pin during reset, so a line held low
  // through reset cannot look like an edge afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      nmi_n_q   <= nmi_n;
      pending_q <= 1'b0;
    end else begin
      nmi_n_q   <= nmi_n_d;
      pending_q <= pending_d;
    end
  end

  assign nmi_pending = pending_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// 6502-style interrupt entry sequencer: arbitrates RESET/NMI/IRQ/BRK, pushes
// PCH, PCL and P, then loads the vector into PC. Optional macro
// INTERRUPT_NMI_HIJACK_EN lets a pending NMI steal the vector of an IRQ/BRK.
module interrupt_sequencer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_en,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        i_flag,
  input  logic        fetch_boundary,
  input  logic        brk_req,
  input  logic [15:0] pc_in,
  input  logic [7:0]  sp_in,
  input  logic [7:0]  p_in,
  input  logic [7:0]  rd,
  output logic        busy,
  output logic [15:0] addr,
  output logic [7:0]  wdata,
  output logic        mem_write,
  output logic        sp_dec,
  output logic        pcl_write,
  output logic        pch_write,
  output logic        pcl_src,
  output logic        pch_src,
  output logic        set_i
);

  int_state_t  state_q, state_d;
  int_kind_t   kind_q, kind_d;
  logic        nmi_pending;
  logic        nmi_clear;
  logic        irq_active;
  logic        push_en;
  logic [15:0] stack_addr;
  logic [15:0] vec_base;

  assign irq_active = !irq_n && !i_flag;
  assign nmi_clear  = (state_q == VEC_L) && (kind_q == NMI);

  nmi_edge_detector u_nmi_edge (
    .clk         (clk),
    .reset       (reset),
    .cpu_en      (cpu_en),
    .nmi_n       (nmi_n),
    .clear       (nmi_clear),
    .nmi_pending (nmi_pending)
  );

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    if (cpu_en) begin
      case (state_q)
        IDLE: begin
          // BRK is an instruction already committed by the decoder, so it goes first.
          if (brk_req) begin
            state_d = PUSH_PCH;
            kind_d  = BRK;
          end else if (fetch_boundary && (nmi_pending || irq_active)) begin
            state_d = DUMMY;
            kind_d  = nmi_pending ? NMI : IRQ;
          end
        end
        DUMMY:    state_d = PUSH_PCH;
        PUSH_PCH: state_d = PUSH_PCL;
        PUSH_PCL: state_d = PUSH_P;
        PUSH_P: begin
          state_d = VEC_L;
`ifdef INTERRUPT_NMI_HIJACK_EN
          // P is already on the stack, so retargeting the kind only moves the vector.
          if (nmi_pending && ((kind_q == IRQ) || (kind_q == BRK))) begin
            kind_d = NMI;
          end
`endif
        end
        VEC_L:    state_d = VEC_H;
        VEC_H:    state_d = IDLE;
        RST_HOLD: state_d = DUMMY;
        default:  state_d = RST_HOLD;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; all decisions live in always_comb.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RST_HOLD;
      kind_q  <= RST;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
    end
  end

  assign push_en    = (kind_q != RST);
  assign stack_addr = {STACK_PAGE, sp_in};
  assign vec_base   = vector_base(kind_q);

  always_comb begin
    busy      = (state_q != IDLE);
    addr      = 16'h0000;
    wdata     = 8'h00;
    mem_write = 1'b0;
    sp_dec    = 1'b0;
    pcl_write = 1'b0;
    pch_write = 1'b0;
    pcl_src   = 1'b0;
    pch_src   = 1'b0;
    set_i     = 1'b0;
    case (state_q)
      DUMMY: begin
        addr = pc_in;
      end
      PUSH_PCH: begin
        addr      = stack_addr;
        wdata     = pc_in[15:8];
        mem_write = push_en;
        sp_dec    = 1'b1;
      end
      PUSH_PCL: begin
        addr      = stack_addr;
        wdata     = pc_in[7:0];
        mem_write = push_en;
        sp_dec    = 1'b1;
      end
      PUSH_P: begin
        addr      = stack_addr;
        wdata     = p_in | P_UNUSED | ((kind_q == BRK) ? P_BREAK : 8'h00);
        mem_write = push_en;
        sp_dec    = 1'b1;
      end
      VEC_L: begin
        addr      = vec_base;
        pcl_write = 1'b1;
        pcl_src   = 1'b1;
        set_i     = 1'b1;
      end
      VEC_H: begin
        addr      = vec_base + 16'd1;
        pch_write = 1'b1;
        pch_src   = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: models memory, PC and SP around the
// DUT and checks reset, IRQ, BRK, NMI priority, NMI hijack and stall/reset cases.
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        reset, cpu_en, nmi_n, irq_n, i_flag, fetch_boundary, brk_req;
  logic [15:0] pc;
  logic [7:0]  sp, p, rd;
  logic        busy, mem_write, sp_dec, pcl_write, pch_write, pcl_src, pch_src, set_i;
  logic [15:0] addr;
  logic [7:0]  wdata;

  logic [7:0]  mem [0:65535];
  logic [15:0] wr_addr [0:7];
  logic [7:0]  wr_data [0:7];
  int          wr_n, sp_dec_cnt, seti_cnt, pcl_cnt, pch_cnt, busy_cnt;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  assign rd = mem[addr];

  interrupt_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_en         (cpu_en),
    .nmi_n          (nmi_n),
    .irq_n          (irq_n),
    .i_flag         (i_flag),
    .fetch_boundary (fetch_boundary),
    .brk_req        (brk_req),
    .pc_in          (pc),
    .sp_in          (sp),
    .p_in           (p),
    .rd             (rd),
    .busy           (busy),
    .addr           (addr),
    .wdata          (wdata),
    .mem_write      (mem_write),
    .sp_dec         (sp_dec),
    .pcl_write      (pcl_write),
    .pch_write      (pch_write),
    .pcl_src        (pcl_src),
    .pch_src        (pch_src),
    .set_i          (set_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_push(input string tag, input int idx, input logic [15:0] a,
                            input logic [7:0] d);
    check({tag, "_addr"}, {16'h0000, wr_addr[idx]}, {16'h0000, a});
    check({tag, "_data"}, {24'h000000, wr_data[idx]}, {24'h000000, d});
  endtask

  task automatic clear_log();
    wr_n       = 0;
    sp_dec_cnt = 0;
    seti_cnt   = 0;
    pcl_cnt    = 0;
    pch_cnt    = 0;
    busy_cnt   = 0;
  endtask

  // One CPU cycle: observe the DUT mid-cycle, apply its effect on memory/PC/SP
  // (what the surrounding registers do at the edge), then step past the edge.
  task automatic cyc();
    @(negedge clk);
    if (cpu_en) begin
      if (busy) busy_cnt++;
      if (set_i) seti_cnt++;
      if (mem_write) begin
        if (wr_n < 8) begin
          wr_addr[wr_n] = addr;
          wr_data[wr_n] = wdata;
        end
        wr_n++;
        mem[addr] = wdata;
      end
      if (pcl_write) begin
        pcl_cnt++;
        if (pcl_src) pc[7:0] = rd;
      end
      if (pch_write) begin
        pch_cnt++;
        if (pch_src) pc[15:8] = rd;
      end
      if (sp_dec) begin
        sp_dec_cnt++;
        sp = sp - 8'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hFFFA] = 8'h00; mem[16'hFFFB] = 8'h90;
    mem[16'hFFFC] = 8'h34; mem[16'hFFFD] = 8'h12;
    mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'hA0;

    reset = 1'b1; cpu_en = 1'b1; nmi_n = 1'b1; irq_n = 1'b1; i_flag = 1'b1;
    fetch_boundary = 1'b0; brk_req = 1'b0;
    pc = 16'h0000; sp = 8'hFD; p = 8'h00;
    clear_log();
    @(posedge clk); #1;
    run(2);

    // Reset state
    check("rst_busy", busy, 1);
    check("rst_strobes", {mem_write, sp_dec, pcl_write, pch_write, set_i, pcl_src, pch_src}, 0);
    check("rst_addr", addr, 16'h0000);
    check("rst_wdata", wdata, 8'h00);

    // Reset sequence: PCL lands after 6 enabled cycles, PCH after 7
    clear_log();
    reset = 1'b0;
    run(6);
    check("rst_busy_6", busy, 1);
    check("rst_pc_6", pc, 16'h0034);
    run(1);
    check("rst_pc", pc, 16'h1234);
    check("rst_idle", busy, 0);
    check("rst_no_writes", wr_n, 0);
    check("rst_sp_dec", sp_dec_cnt, 3);
    check("rst_set_i", seti_cnt, 1);

    // IRQ gating: masked, off-boundary, released before boundary
    irq_n = 1'b0; i_flag = 1'b1; fetch_boundary = 1'b1;
    cyc();
    check("irq_masked", busy, 0);
    i_flag = 1'b0; fetch_boundary = 1'b0;
    cyc();
    check("irq_no_boundary", busy, 0);
    irq_n = 1'b1; fetch_boundary = 1'b1;
    cyc();
    check("irq_released", busy, 0);

    // IRQ entry, line released once DUMMY has started
    pc = 16'h8005; sp = 8'hFD; p = 8'h20; irq_n = 1'b0;
    clear_log();
    cyc();
    fetch_boundary = 1'b0; irq_n = 1'b1;
    check("irq_dummy_busy", busy, 1);
    check("irq_dummy_addr", addr, 16'h8005);
    run(6);
    check("irq_nwr", wr_n, 3);
    check_push("irq_pch", 0, 16'h01FD, 8'h80);
    check_push("irq_pcl", 1, 16'h01FC, 8'h05);
    check_push("irq_p", 2, 16'h01FB, 8'h20);
    check("irq_pc", pc, 16'hA000);
    check("irq_sp", sp, 8'hFA);
    check("irq_pcl_pulse", pcl_cnt, 1);
    check("irq_pch_pulse", pch_cnt, 1);
    check("irq_idle", busy, 0);

    // BRK with SP wrapping inside page 1
    pc = 16'h4002; sp = 8'h01; p = 8'h00;
    clear_log();
    brk_req = 1'b1;
    cyc();
    brk_req = 1'b0;
    run(6);
    check("brk_busy_cycles", busy_cnt, 5);
    check_push("brk_pch", 0, 16'h0101, 8'h40);
    check_push("brk_pcl", 1, 16'h0100, 8'h02);
    check_push("brk_p", 2, 16'h01FF, 8'h30);
    check("brk_pc", pc, 16'hA000);
    check("brk_set_i", seti_cnt, 1);

    // NMI beats a simultaneous IRQ; IRQ follows at the next boundary
    pc = 16'h8005; sp = 8'hFD; p = 8'h20;
    irq_n = 1'b0; i_flag = 1'b0; nmi_n = 1'b0;
    clear_log();
    cyc();
    fetch_boundary = 1'b1;
    cyc();
    fetch_boundary = 1'b0;
    run(6);
    check("nmi_pc", pc, 16'h9000);
    check("nmi_p_no_b", wr_data[2], 8'h20);
    nmi_n = 1'b1; fetch_boundary = 1'b1;
    cyc();
    fetch_boundary = 1'b0;
    run(6);
    check("irq_after_nmi_pc", pc, 16'hA000);
    irq_n = 1'b1;

    // NMI edge during PUSH_PCL of a BRK
    pc = 16'h4002; sp = 8'hFD; p = 8'h00;
    clear_log();
    brk_req = 1'b1;
    cyc();
    brk_req = 1'b0;
    cyc();
    nmi_n = 1'b0;
    run(2);
    nmi_n = 1'b1;
    run(2);
    check("brk_nmi_p", wr_data[2], 8'h30);
`ifdef INTERRUPT_NMI_HIJACK_EN
    check("hijack_pc", pc, 16'h9000);
    fetch_boundary = 1'b1;
    cyc();
    fetch_boundary = 1'b0;
    check("hijack_nmi_consumed", busy, 0);
`else
    check("no_hijack_pc", pc, 16'hA000);
    fetch_boundary = 1'b1;
    cyc();
    fetch_boundary = 1'b0;
    run(6);
    check("nmi_next_boundary_pc", pc, 16'h9000);
`endif

    // Stall mid-PUSH_PCH, then reset during VEC_L
    pc = 16'h8005; sp = 8'hFD; p = 8'h20; irq_n = 1'b0; i_flag = 1'b0;
    fetch_boundary = 1'b1;
    clear_log();
    cyc();
    fetch_boundary = 1'b0; irq_n = 1'b1;
    cyc();
    cpu_en = 1'b0;
    run(3);
    check("frozen_addr", addr, 16'h01FD);
    check("frozen_wdata", wdata, 8'h80);
    cpu_en = 1'b1;
    run(3);
    check("stall_sp_dec", sp_dec_cnt, 3);
    check("stall_nwr", wr_n, 3);
    check("stall_vec_l_addr", addr, 16'hFFFE);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("mid_rst_busy", busy, 1);
    check("mid_rst_addr", addr, 16'h0000);
    check("mid_rst_no_pch", pch_cnt, 0);
    check("mid_rst_pc", pc, 16'h8000);
    clear_log();
    run(7);
    check("restart_pc", pc, 16'h1234);
    check("restart_no_writes", wr_n, 0);
    check("restart_sp_dec", sp_dec_cnt, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
# interrupt_sequencer

Sequences the 6502-style interrupt entry (RESET, NMI, IRQ, BRK) for the console CPU. It arbitrates pending interrupts at instruction boundaries, pushes PCH, PCL and P onto the stack page, and fetches the 16-bit vector. It sits directly upstream of the PC register and drives its PCL/PCH write enables and source selects so the vector bytes read from memory are loaded into PC. It owns the bus address, write data and memory write strobe while `busy` is high.

## Interface
- No parameters.
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `cpu_en`  in  1  CPU clock enable; when low, all state holds (DMA stall)
- `nmi_n`  in  1  NMI line, active low, falling-edge sensitive
- `irq_n`  in  1  IRQ line, active low, level sensitive
- `i_flag`  in  1  current P.I
- `fetch_boundary`  in  1  current cycle is an opcode-fetch cycle
- `brk_req`  in  1  decoder has decoded BRK; PC already advanced past the padding byte
- `pc_in`  in  16  current PC
- `sp_in`  in  8  current stack pointer
- `p_in`  in  8  current status register
- `rd`  in  8  memory read data
- `busy`  out  1  sequence in progress; decoder suppresses fetch and `pc_inc`
- `addr`  out  16  bus address while busy
- `wdata`  out  8  bus write data
- `mem_write`  out  1  write strobe
- `sp_dec`  out  1  decrement SP this cycle
- `pcl_write`  out  1  load PCL
- `pch_write`  out  1  load PCH
- `pcl_src`  out  1  PCL source select; 1 selects memory read data
- `pch_src`  out  1  PCH source select; 1 selects memory read data
- `set_i`  out  1  set P.I this cycle

## Operation
- States: IDLE, DUMMY, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_L, VEC_H, RST_HOLD.
- Kind register: RST, NMI, IRQ, BRK. Priority when several events are pending: RST > NMI > IRQ.
- NMI: a falling edge of `nmi_n`, sampled on `cpu_en` cycles, sets `nmi_pending`. `nmi_pending` clears in VEC_L when the NMI vector is used.
- IRQ is active when `!irq_n && !i_flag` at the cycle it is sampled.
- IDLE + `fetch_boundary` + (`nmi_pending` | IRQ active) → DUMMY. The kind is latched at this point.
- IDLE + `brk_req` → PUSH_PCH with kind=BRK. `brk_req` is ignored in every other state.
- DUMMY: `addr`=`pc_in`, read data is discarded.
- PUSH_PCH: `addr`=0x0100|`sp_in`, `wdata`=`pc_in[15:8]`, `mem_write`=1, `sp_dec`=1.
- PUSH_PCL: same as PUSH_PCH with `wdata`=`pc_in[7:0]`.
- PUSH_P: same as PUSH_PCH with `wdata`=`p_in`|0x20, plus 0x10 when kind=BRK.
- For kind=RST, the three push states keep the stack address and `sp_dec`=1 but force `mem_write`=0.
- VEC_L: `addr`=vector base, `pcl_write`=1, `pcl_src`=1, `set_i`=1.
- VEC_H: `addr`=vector base+1, `pch_write`=1, `pch_src`=1, then → IDLE.
- Vector base: RST 0xFFFC, NMI 0xFFFA, IRQ/BRK 0xFFFE.
- `busy`=1 in every state except IDLE.

## Timing
- While `reset` is high: state=RST_HOLD, `nmi_pending`=0, kind=RST.
- Reset values of outputs: `busy`=1; `mem_write`, `sp_dec`, `pcl_write`, `pch_write`, `set_i`, `pcl_src`, `pch_src` = 0; `addr`=0x0000; `wdata`=0x00.
- First `cpu_en` cycle after `reset` falls: RST_HOLD → DUMMY.
- Latency:
  - IRQ/NMI: 7 enabled cycles from the boundary cycle to PC = vector.
  - BRK: 5 enabled cycles from `brk_req`.
  - RST: 7 enabled cycles after RST_HOLD.
- `pcl_write` and `pch_write` each pulse for exactly one enabled cycle. Outputs are combinational from state; PC updates at the clock edge that ends VEC_L / VEC_H.
- `cpu_en` low: state, kind and the `nmi_pending` edge sampler all freeze. Strobes may remain asserted; the PC register gates them with `cpu_en`.
- `reset` asserted mid-sequence → RST_HOLD on the next edge. An incomplete push is abandoned.
- NMI edge during a sequence sets `nmi_pending` and is serviced at the next boundary (see Configuration).
- IRQ released before the boundary cycle: no entry. IRQ released after DUMMY has started: the sequence completes.
- `sp_in` wrap 0x00 → 0xFF is handled by the SP register; the address stays within page 0x01.

## Configuration
- `INTERRUPT_NMI_HIJACK_EN` defined: during kind IRQ/BRK, if `nmi_pending` is set at or before the PUSH_P cycle, VEC_L/VEC_H use 0xFFFA and `nmi_pending` clears in VEC_L. The pushed P keeps B as latched.
- Undefined: the vector is fixed by the latched kind, and the NMI waits for the next boundary.

## Structure
- Shared `cpu_pkg`:
  - `int_state_t` enum
  - `int_kind_t` enum
  - constants `VEC_NMI`, `VEC_RST`, `VEC_IRQ`, `STACK_PAGE`
- Sub-module `nmi_edge_detector`:
  - inputs: `clk`, `reset`, `cpu_en`, `nmi_n`, `clear`
  - output: `nmi_pending`

## Test plan
- Reset released, memory 0xFFFC=0x34, 0xFFFD=0x12 → no writes, `sp_dec` ×3, PC=0x1234 after 7 enabled cycles, `set_i` pulsed once.
- IRQ low, `i_flag`=0, PC=0x8005, SP=0xFD, P=0x20 at boundary → writes 0x01FD=0x80, 0x01FC=0x05, 0x01FB=0x20, then PC=vector at 0xFFFE.
- `brk_req` with P=0x00 → pushed P=0x30, vector 0xFFFE, `busy` for exactly 5 enabled cycles.
- `nmi_n` falling edge while IRQ is also active → NMI vector 0xFFFA used, `nmi_pending` cleared, IRQ taken at the following boundary.
- NMI edge during PUSH_PCL of a BRK: with the macro defined → vector 0xFFFA, pushed P has B=1; without the macro → vector 0xFFFE, NMI taken next boundary.
- `cpu_en` held low 3 cycles mid-PUSH_PCH, then `reset` asserted in VEC_L → state frozen with no extra `sp_dec`; PC is not loaded from VEC_H, and the reset sequence restarts.
